// File: rtl/mac_tx_stream_arbiter.sv
// Round-robin, whole-frame arbiter sharing the 8-bit MAC TX AXI-Stream between N_SRC sources.
// A granted source that idles mid-frame for STALL_MAX cycles has its frame aborted and drained.
module mac_tx_stream_arbiter #(
  parameter int N_SRC     = 2,
  parameter int STALL_MAX = 32
) (
  input  logic               tx_mac_aclk,
  input  logic               tx_mac_aclk_rst,
  input  logic [N_SRC*8-1:0] s_tdata,
  input  logic [N_SRC-1:0]   s_tvalid,
  input  logic [N_SRC-1:0]   s_tlast,
  input  logic [N_SRC-1:0]   s_tuser,
  output logic [N_SRC-1:0]   s_tready,
  output logic [7:0]         m_tdata,
  output logic               m_tvalid,
  output logic               m_tlast,
  output logic               m_tuser,
  input  logic               m_tready,
  output logic [N_SRC-1:0]   grant,
  output logic [15:0]        abort_cnt
);

  localparam int IW = $clog2(N_SRC);
  localparam int SW = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, PASS, ABORT, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] gidx, gidx_nxt;
  logic [IW-1:0] last_grant, last_grant_nxt;
  logic [SW-1:0] stall_cnt, stall_cnt_nxt;
  logic [15:0]   abort_cnt_nxt;

  logic [IW-1:0] pick, cand;
  logic          req_any;
  logic [7:0]    src_data;
  logic          src_valid, src_last, src_user;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [SW-1:0] stall_inc(input logic [SW-1:0] v);
    if (32'(v) >= 32'(STALL_MAX)) return v;
    return v + SW'(1);
  endfunction

  // True when this idle cycle is the one that brings the count up to STALL_MAX.
  function automatic logic stall_limit(input logic [SW-1:0] v);
    return (STALL_MAX > 0) && ((32'(v) + 32'd1) == 32'(STALL_MAX));
  endfunction

  always_comb begin
    req_any = 1'b0;
    pick    = last_grant;
    cand    = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = IW'((int'(last_grant) + k) % N_SRC);
      if (!req_any && s_tvalid[cand]) begin
        req_any = 1'b1;
        pick    = cand;
      end
    end
  end

  always_comb begin
    src_data  = 8'(s_tdata >> (8 * gidx));
    src_valid = s_tvalid[gidx];
    src_last  = s_tlast[gidx];
    src_user  = s_tuser[gidx];
  end

  always_comb begin
    state_nxt      = state;
    gidx_nxt       = gidx;
    last_grant_nxt = last_grant;
    stall_cnt_nxt  = '0;
    abort_cnt_nxt  = abort_cnt;
    m_tdata        = 8'h00;
    m_tvalid       = 1'b0;
    m_tlast        = 1'b0;
    m_tuser        = 1'b0;
    s_tready       = '0;
    grant          = '0;
    case (state)
      IDLE: begin
        if (req_any) begin
          gidx_nxt  = pick;
          state_nxt = PASS;
        end
      end
      PASS: begin
        grant[gidx]    = 1'b1;
        m_tdata        = src_data;
        m_tvalid       = src_valid;
        m_tlast        = src_last;
        m_tuser        = src_user;
        s_tready[gidx] = m_tready;
        stall_cnt_nxt  = src_valid ? '0 : stall_inc(stall_cnt);
        if (src_valid && m_tready && src_last) begin
          state_nxt      = IDLE;
          last_grant_nxt = gidx;
          stall_cnt_nxt  = '0;
        end else if (!src_valid && stall_limit(stall_cnt)) begin
          state_nxt = ABORT;
        end
      end
      ABORT: begin
        grant[gidx] = 1'b1;
        m_tvalid    = 1'b1;
        m_tlast     = 1'b1;
        m_tuser     = 1'b1;
        if (m_tready) begin
          state_nxt     = DRAIN;
          abort_cnt_nxt = sat_inc16(abort_cnt);
        end
      end
      DRAIN: begin
        grant[gidx]    = 1'b1;
        s_tready[gidx] = 1'b1;
        if (src_valid && src_last) begin
          state_nxt      = IDLE;
          last_grant_nxt = gidx;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge tx_mac_aclk or posedge tx_mac_aclk_rst) begin
    if (tx_mac_aclk_rst) begin
      state      <= IDLE;
      gidx       <= '0;
      last_grant <= IW'(N_SRC - 1);
      stall_cnt  <= '0;
      abort_cnt  <= 16'h0000;
    end else begin
      state      <= state_nxt;
      gidx       <= gidx_nxt;
      last_grant <= last_grant_nxt;
      stall_cnt  <= stall_cnt_nxt;
      abort_cnt  <= abort_cnt_nxt;
    end
  end

endmodule
